ring_route_arbiter: RTL and testbench

Sequential route-setting controller for the 8-route ring interlock (routes A..H, index 0..7). It accepts level route requests, grants at most one new route per cycle by round-robin among requests whose conflicting neighbours are free, and sequences each granted route through timed setting and release phases. Its per-route lock outputs drive the combinational interlock equations, so no two conflicting routes are ever simultaneously non-free.

---
 rtl/ring_interlock_pkg.sv | 35 +++
 rtl/ring_route_fsm.sv | 79 +++++++
 rtl/ring_route_arbiter.sv | 92 +++++++++
 tb/tb_ring_route_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_interlock_pkg.sv
// Shared types and constants for the 8-route ring interlock: route indices,
// per-route state encoding and the ring-adjacency conflict mask.
package ring_interlock_pkg;

  localparam int NUM_ROUTES = 8;
  localparam int ROUTE_W    = 3;

  localparam int ROUTE_A = 0;
  localparam int ROUTE_B = 1;
  localparam int ROUTE_C = 2;
  localparam int ROUTE_D = 3;
  localparam int ROUTE_E = 4;
  localparam int ROUTE_F = 5;
  localparam int ROUTE_G = 6;
  localparam int ROUTE_H = 7;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    SETTING   = 2'd1,
    LOCKED    = 2'd2,
    RELEASING = 2'd3
  } route_state_t;

  // Route k conflicts with its two ring neighbours; H and A wrap around.
  function automatic logic [NUM_ROUTES-1:0] neighbours(input int unsigned k);
    logic [NUM_ROUTES-1:0] mask;
    logic [ROUTE_W-1:0]    kk;
    mask = '0;
    kk   = ROUTE_W'(k);
    mask[kk + ROUTE_W'(1)] = 1'b1;
    mask[kk - ROUTE_W'(1)] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/ring_route_fsm.sv
// One route's lifecycle: FREE -> SETTING -> LOCKED -> RELEASING -> FREE,
// with a down-counter timing the setting and release phases.
module ring_route_fsm
  import ring_interlock_pkg::*;
#(
  parameter int unsigned SET_CYCLES = 4,
  parameter int unsigned REL_CYCLES = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         start,
  input  logic         release_req,
  output route_state_t state,
  output logic         busy,
  output logic         err
);

  route_state_t state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err     = 1'b0;
    unique case (state_q)
      FREE: begin
        err = release_req;
        if (start) begin
          state_d = SETTING;
          cnt_d   = 8'(SET_CYCLES - 1);
        end
      end
      SETTING: begin
        // A release while setting aborts straight into flank-protected release.
        if (release_req) begin
          state_d = RELEASING;
          cnt_d   = 8'(REL_CYCLES - 1);
        end else if (cnt_q == 8'd0) begin
          state_d = LOCKED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LOCKED: begin
        if (release_req) begin
          state_d = RELEASING;
          cnt_d   = 8'(REL_CYCLES - 1);
        end
      end
      RELEASING: begin
        err = release_req;
        if (cnt_q == 8'd0) begin
          state_d = FREE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = FREE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FREE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
  assign busy  = (state_q != FREE);

endmodule

// File: rtl/ring_route_arbiter.sv
// Ring route-setting controller: round-robin grants at most one conflict-free
// route per cycle and sequences each route through its timed phases.
module ring_route_arbiter
  import ring_interlock_pkg::*;
#(
  parameter int unsigned SET_CYCLES = 4,
  parameter int unsigned REL_CYCLES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_req,
  input  logic [7:0] i_release,
  output logic [7:0] o_grant,
  output logic [7:0] o_busy,
  output logic [7:0] o_setting,
  output logic       o_err
);

  route_state_t              state [NUM_ROUTES];
  logic [NUM_ROUTES-1:0]     busy;
  logic [NUM_ROUTES-1:0]     err_vec;
  logic [NUM_ROUTES-1:0]     elig;
  logic [NUM_ROUTES-1:0]     start;
  logic [ROUTE_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ROUTE_W-1:0]        idx;
  logic                      found;
  logic                      err_q, err_d;

  // A route is eligible only when it and both neighbours are FREE; with one
  // grant per cycle no neighbour can be granted alongside it.
  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < NUM_ROUTES; k++) begin
      elig[k] = i_req[k] && !busy[k] && ((busy & neighbours(k)) == '0);
    end
  end

  always_comb begin
    start    = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_ROUTES; i++) begin
      idx = rr_ptr_q + ROUTE_W'(i);
      if (!found && elig[idx]) begin
        found      = 1'b1;
        start[idx] = 1'b1;
        rr_ptr_d   = idx + ROUTE_W'(1);
      end
    end
  end

  assign err_d = |err_vec;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  for (genvar k = 0; k < NUM_ROUTES; k++) begin : g_route
    ring_route_fsm #(
      .SET_CYCLES (SET_CYCLES),
      .REL_CYCLES (REL_CYCLES)
    ) u_fsm (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .start       (start[k]),
      .release_req (i_release[k]),
      .state       (state[k]),
      .busy        (busy[k]),
      .err         (err_vec[k])
    );
  end

  always_comb begin
    o_grant   = '0;
    o_setting = '0;
    for (int unsigned k = 0; k < NUM_ROUTES; k++) begin
      o_grant[k]   = (state[k] == LOCKED);
      o_setting[k] = (state[k] == SETTING);
    end
  end

  assign o_busy = busy;
  assign o_err  = err_q;

endmodule

// File: tb/tb_ring_route_arbiter.sv
// Self-checking bench for ring_route_arbiter: a timestamp-based route model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ring_route_arbiter;

  localparam int SET_CYCLES = 4;
  localparam int REL_CYCLES = 3;
  localparam int NEVER      = 32'h3fff_ffff;

  logic       i_clk   = 1'b0;
  logic       i_rst_n = 1'b1;
  logic [7:0] i_req     = 8'h00;
  logic [7:0] i_release = 8'h00;
  logic [7:0] o_grant, o_busy, o_setting;
  logic       o_err;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  ring_route_arbiter #(
    .SET_CYCLES (SET_CYCLES),
    .REL_CYCLES (REL_CYCLES)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req),
    .i_release (i_release),
    .o_grant   (o_grant),
    .o_busy    (o_busy),
    .o_setting (o_setting),
    .o_err     (o_err)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each route is described by the edge at which it locks and the edge
  // at which it becomes free again (NEVER while held); states follow from now.
  int   now;
  int   lock_at [8];
  int   free_at [8];
  int   rr;
  logic m_err;
  logic [7:0] m_fr;
  bit   m_err_n;
  int   m_win;

  function automatic bit m_free(input int k);
    return now >= free_at[k];
  endfunction
  function automatic bit m_setting(input int k);
    return free_at[k] == NEVER && now < lock_at[k];
  endfunction
  function automatic bit m_locked(input int k);
    return free_at[k] == NEVER && now >= lock_at[k];
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      now   = 0;
      rr    = 0;
      m_err = 1'b0;
      for (int k = 0; k < 8; k++) begin
        lock_at[k] = 0;
        free_at[k] = 0;
      end
    end else begin
      for (int k = 0; k < 8; k++) m_fr[k] = m_free(k);
      m_err_n = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (i_release[k]) begin
          if (m_setting(k) || m_locked(k)) free_at[k] = now + 1 + REL_CYCLES;
          else m_err_n = 1'b1;
        end
      end
      m_win = -1;
      for (int i = 0; i < 8; i++) begin
        int k;
        k = (rr + i) % 8;
        if (m_win < 0 && i_req[k] && m_fr[k] && m_fr[(k + 1) % 8] && m_fr[(k + 7) % 8])
          m_win = k;
      end
      if (m_win >= 0) begin
        lock_at[m_win] = now + 1 + SET_CYCLES;
        free_at[m_win] = NEVER;
        rr = (m_win + 1) % 8;
      end
      m_err = m_err_n;
      now   = now + 1;
    end
  end

  logic [7:0] eg, eb, es;
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      for (int k = 0; k < 8; k++) begin
        eg[k] = m_locked(k);
        eb[k] = !m_free(k);
        es[k] = m_setting(k);
      end
      check("model_grant", o_grant, eg);
      check("model_busy", o_busy, eb);
      check("model_setting", o_setting, es);
      check("model_err", {7'b0, o_err}, {7'b0, m_err});
    end
  end

  int q[$];

  initial begin
    #1 i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    check("reset_grant", o_grant, 8'h00);
    check("reset_busy", o_busy, 8'h00);
    check("reset_setting", o_setting, 8'h00);
    check("reset_err", {7'b0, o_err}, 8'h00);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Single request on B, released at cycle 10.
    i_req = 8'h02;
    @(negedge i_clk);
    check("single_busy_e0", o_busy, 8'h02);
    check("single_setting_e0", o_setting, 8'h02);
    i_req = 8'h00;
    repeat (3) @(negedge i_clk);
    check("single_grant_e3", o_grant, 8'h00);
    @(negedge i_clk);
    check("single_grant_e4", o_grant, 8'h02);
    repeat (5) @(negedge i_clk);
    i_release = 8'h02;
    @(negedge i_clk);
    i_release = 8'h00;
    check("single_grant_e10", o_grant, 8'h00);
    check("single_busy_e10", o_busy, 8'h02);
    repeat (2) @(negedge i_clk);
    check("single_busy_e12", o_busy, 8'h02);
    @(negedge i_clk);
    check("single_busy_e13", o_busy, 8'h00);

    // Neighbour block: B locked, C waits until B is FREE.
    i_req = 8'h02;
    @(negedge i_clk);
    i_req = 8'h00;
    repeat (4) @(negedge i_clk);
    check("nb_b_locked", o_grant, 8'h02);
    i_req = 8'h04;
    repeat (3) @(negedge i_clk);
    check("nb_c_blocked", o_busy, 8'h02);
    i_release = 8'h02;
    @(negedge i_clk);
    i_release = 8'h00;
    check("nb_b_releasing", o_busy, 8'h02);
    repeat (3) @(negedge i_clk);
    check("nb_b_free", o_busy, 8'h00);
    @(negedge i_clk);
    check("nb_c_granted", o_setting, 8'h04);
    i_req = 8'h00;
    i_release = 8'h04;
    @(negedge i_clk);
    i_release = 8'h00;
    repeat (3) @(negedge i_clk);
    check("nb_all_free", o_busy, 8'h00);

    // Wrap-around: H blocks A; then A and E together from rr_ptr=0.
    i_req = 8'h80;
    @(negedge i_clk);
    i_req = 8'h00;
    repeat (4) @(negedge i_clk);
    check("wrap_h_locked", o_grant, 8'h80);
    i_req = 8'h01;
    repeat (2) @(negedge i_clk);
    check("wrap_a_blocked", o_busy, 8'h80);
    i_release = 8'h80;
    i_req = 8'h00;
    @(negedge i_clk);
    i_release = 8'h00;
    repeat (3) @(negedge i_clk);
    check("wrap_h_free", o_busy, 8'h00);
    i_req = 8'h11;
    @(negedge i_clk);
    check("wrap_a_first", o_busy, 8'h01);
    @(negedge i_clk);
    check("wrap_e_second", o_busy, 8'h11);
    i_req = 8'h00;
    i_release = 8'h11;
    @(negedge i_clk);
    i_release = 8'h00;
    repeat (3) @(negedge i_clk);
    check("wrap_all_free", o_busy, 8'h00);

    // Fairness: A and E held, each route released as soon as it locks.
    i_req = 8'h11;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      i_release = o_grant;
      for (int k = 0; k < 8; k++) if (o_grant[k]) q.push_back(k);
      if (q.size() >= 4) i_req = 8'h00;
    end
    i_release = 8'h00;
    @(negedge i_clk);
    check("fair_count", 8'(q.size()), 8'd4);
    if (q.size() >= 4) begin
      check("fair_0", 8'(q[0]), 8'd0);
      check("fair_1", 8'(q[1]), 8'd4);
      check("fair_2", 8'(q[2]), 8'd0);
      check("fair_3", 8'(q[3]), 8'd4);
    end
    check("fair_all_free", o_busy, 8'h00);

    // Abort D during SETTING, then illegal releases.
    i_req = 8'h08;
    @(negedge i_clk);
    check("abort_d_busy", o_busy, 8'h08);
    i_req = 8'h00;
    i_release = 8'h08;
    @(negedge i_clk);
    i_release = 8'h00;
    check("abort_d_releasing", o_busy, 8'h08);
    check("abort_d_no_setting", o_setting, 8'h00);
    check("abort_d_no_grant", o_grant, 8'h00);
    repeat (3) @(negedge i_clk);
    check("abort_d_free", o_busy, 8'h00);
    i_release = 8'h20;
    @(negedge i_clk);
    i_release = 8'h00;
    check("err_pulse", {7'b0, o_err}, 8'h01);
    @(negedge i_clk);
    check("err_clear", {7'b0, o_err}, 8'h00);
    i_release = 8'hA0;
    @(negedge i_clk);
    i_release = 8'h00;
    check("err_multi_pulse", {7'b0, o_err}, 8'h01);
    @(negedge i_clk);
    check("err_multi_clear", {7'b0, o_err}, 8'h00);

    // Asynchronous reset while three routes are busy.
    i_req = 8'h15;
    repeat (3) @(negedge i_clk);
    i_req = 8'h00;
    check("rst_three_busy", o_busy, 8'h15);
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_async_grant", o_grant, 8'h00);
    check("rst_async_busy", o_busy, 8'h00);
    check("rst_async_setting", o_setting, 8'h00);
    check("rst_async_err", {7'b0, o_err}, 8'h00);
    i_req = 8'h01;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_regrant_a", o_busy, 8'h01);
    i_req = 8'h00;
    repeat (6) @(negedge i_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
